// File: rtl/bridge_req_arbiter.sv
// ---------------------------------------------------------------------------
// bridge_req_arbiter
//
// Purpose:
//    Arbitrates N core-side request channels onto the single request port of
//    the host bridge driver. Exactly one request is in flight at a time. The
//    winner is chosen by fixed priority (ch0 highest) or round-robin. Its
//    command word and parameters are registered at grant time. The driver's
//    result is returned to the winner with a one-cycle ch_done pulse. An
//    optional timeout aborts a request that the driver never completes.
//
// Ports:
//    clk          in   single clock, all logic on the rising edge
//    reset_n      in   asynchronous active-low reset
//    ch_valid     in   per-channel request, held high until that channel's ch_done
//    ch_word      in   per-channel command word, ch i at [i*WORD_W +: WORD_W]
//    ch_param     in   per-channel parameters, ch i at [i*PARAM_W +: PARAM_W]
//    ch_done      out  one-cycle completion pulse to the granted channel
//    ch_timeout   out  qualifies ch_done: request was aborted by the timeout
//    ch_result    out  result for the completing channel, held until next completion
//    grant_idx    out  index of the channel in flight
//    req_valid    out  request to the bridge driver
//    req_word     out  registered command word of the granted channel
//    req_param    out  registered parameters of the granted channel
//    req_done     in   driver completion pulse, req_result valid in the same cycle
//    req_result   in   driver result word
// ---------------------------------------------------------------------------
module bridge_req_arbiter #(
   parameter int NUM_CH      = 8,
   parameter int WORD_W      = 32,
   parameter int PARAM_W     = 96,
   parameter int RR_MODE     = 0,
   parameter int TIMEOUT_CYC = 0,
   localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_CH-1:0]          ch_valid,
   input  logic [NUM_CH*WORD_W-1:0]   ch_word,
   input  logic [NUM_CH*PARAM_W-1:0]  ch_param,
   output logic [NUM_CH-1:0]          ch_done,
   output logic                       ch_timeout,
   output logic [WORD_W-1:0]          ch_result,
   output logic [IDX_W-1:0]           grant_idx,
   output logic                       req_valid,
   output logic [WORD_W-1:0]          req_word,
   output logic [PARAM_W-1:0]         req_param,
   input  logic                       req_done,
   input  logic [WORD_W-1:0]          req_result
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam int             CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

   logic [1:0]          r_state;
   logic [IDX_W-1:0]    r_grant;
   logic [IDX_W-1:0]    r_rrPtr;
   logic [WORD_W-1:0]   r_word;
   logic [PARAM_W-1:0]  r_param;
   logic [WORD_W-1:0]   r_result;
   logic                r_timeout;
   logic [CNT_W-1:0]    r_count;

   logic [NUM_CH-1:0]   w_hiMask;
   logic [NUM_CH-1:0]   w_pickSet;
   logic [IDX_W-1:0]    w_winner;
   logic                w_anyValid;
   logic                w_expired;
   logic [NUM_CH-1:0]   w_doneVec;

   // Winner selection. Round-robin is a two-pass search: first the
   // requesters strictly above the last granted index, and if none of those
   // are set, all requesters from ch0 upward. That gives the NUM_CH-1 -> 0 wrap.
   // Fixed priority always uses the second pass. The descending loop leaves
   // the lowest set index in w_winner.
   always_comb begin
      w_hiMask = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_hiMask[k] = ch_valid[k] && (k > int'(r_rrPtr));
      end
      w_pickSet = ((RR_MODE != 0) && (w_hiMask != '0)) ? w_hiMask : ch_valid;
      w_winner  = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (w_pickSet[k]) begin
            w_winner = IDX_W'(k);
         end
      end
   end

   assign w_anyValid = |ch_valid;
   assign w_expired  = (TIMEOUT_CYC > 0) && (r_count == CNT_LAST);

   // Request lifecycle: grant in IDLE, wait for the driver (or the timeout)
   // in ACTIVE, and spend one cycle in DONE to pulse ch_done. The RR pointer
   // only moves in DONE. A request lost to reset therefore never counts as served.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_rrPtr   <= IDX_W'(NUM_CH - 1);
         r_word    <= '0;
         r_param   <= '0;
         r_result  <= '0;
         r_timeout <= 1'b0;
         r_count   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_anyValid) begin
                  r_grant <= w_winner;
                  r_word  <= ch_word[w_winner*WORD_W +: WORD_W];
                  r_param <= ch_param[w_winner*PARAM_W +: PARAM_W];
                  r_count <= '0;
                  r_state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               r_count <= r_count + 1'b1;
               // A driver completion takes precedence over a simultaneous expiry.
               if (req_done) begin
                  r_result  <= req_result;
                  r_timeout <= 1'b0;
                  r_state   <= ST_DONE;
               end else if (w_expired) begin
                  r_result  <= '1;
                  r_timeout <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_rrPtr <= r_grant;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // The completion pulse is decoded from the state register. It stays one-hot
   // and drops as soon as reset is asserted.
   always_comb begin
      w_doneVec = '0;
      if (r_state == ST_DONE) begin
         w_doneVec[r_grant] = 1'b1;
      end
   end

   assign ch_done    = w_doneVec;
   assign ch_timeout = r_timeout;
   assign ch_result  = r_result;
   assign grant_idx  = r_grant;
   assign req_valid  = (r_state == ST_ACTIVE);
   assign req_word   = r_word;
   assign req_param  = r_param;

endmodule
